// File: rtl/mem_access_stage_pkg.sv
// Shared opcode constants, state encoding and memory-op decode for the memory access stage.
// No logic of its own: constants, types and pure decode helpers only.
// Flow control lives in the stage itself; nothing here holds state.
package mem_access_stage_pkg;

    // Major opcodes (instruction bits [31:26])
    localparam logic [5:0] OPC_SPECIAL = 6'b000000;
    localparam logic [5:0] OPC_JAL     = 6'b000011;
    localparam logic [5:0] OPC_LB      = 6'b100000;
    localparam logic [5:0] OPC_LW      = 6'b100011;
    localparam logic [5:0] OPC_LBU     = 6'b100100;
    localparam logic [5:0] OPC_SB      = 6'b101000;
    localparam logic [5:0] OPC_SH      = 6'b101001;
    localparam logic [5:0] OPC_SW      = 6'b101011;

    // Function field of the register-jump instruction, which never writes a register
    localparam logic [5:0] FUNC_JR     = 6'b001000;

    // Link register written by JAL
    localparam logic [4:0] REG_LINK    = 5'd31;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    typedef enum logic [2:0] {
        MOP_NONE,
        MOP_LW,
        MOP_LB,
        MOP_LBU,
        MOP_SW,
        MOP_SH,
        MOP_SB
    } mem_op_e;

    function automatic mem_op_e decode_mem_op(input logic [5:0] opc);
        case (opc)
            OPC_LW:  return MOP_LW;
            OPC_LB:  return MOP_LB;
            OPC_LBU: return MOP_LBU;
            OPC_SW:  return MOP_SW;
            OPC_SH:  return MOP_SH;
            OPC_SB:  return MOP_SB;
            default: return MOP_NONE;
        endcase
    endfunction

    function automatic logic is_load(input mem_op_e op);
        return (op == MOP_LW) || (op == MOP_LB) || (op == MOP_LBU);
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return (op == MOP_SW) || (op == MOP_SH) || (op == MOP_SB);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load byte extraction.
// Purely combinational, zero latency.
// No flow control; outputs follow inputs in the same cycle.
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  mem_op_e     op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0] sel_byte;

    // Big-endian lanes: byte_en[3] and address offset 0 both map to data[31:24]
    always_comb begin
        byte_en = 4'b0000;
        wdata   = 32'h0;
        case (op)
            MOP_SW: begin
                byte_en = 4'b1111;
                wdata   = store_data;
            end
            MOP_SH: begin
                byte_en = addr_lo[1] ? 4'b0011 : 4'b1100;
                wdata   = {2{store_data[15:0]}};
            end
            MOP_SB: begin
                byte_en = 4'b1000 >> addr_lo;
                wdata   = {4{store_data[7:0]}};
            end
            default: begin
                byte_en = 4'b0000;
                wdata   = 32'h0;
            end
        endcase
    end

    // Pick the addressed byte, offset 0 being the most significant byte
    always_comb begin
        sel_byte = 8'h00;
        case (addr_lo)
            2'd0:    sel_byte = rdata[31:24];
            2'd1:    sel_byte = rdata[23:16];
            2'd2:    sel_byte = rdata[15:8];
            default: sel_byte = rdata[7:0];
        endcase
    end

    // Extend the selected byte or pass the full word through
    always_comb begin
        load_data = 32'h0;
        case (op)
            MOP_LW:  load_data = rdata;
            MOP_LB:  load_data = {{24{sel_byte[7]}}, sel_byte};
            MOP_LBU: load_data = {24'h0, sel_byte};
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory access pipeline stage: loads/stores over a req/ack data port, pass-through for ALU results.
// Latency: 1 cycle for non-memory ops, >= 2 cycles for loads/stores (accept edge + ack edge).
// Backpressure: mem_stall holds upstream for all of WAIT; ack or timeout returns to IDLE.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
)(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_insn,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_store_data,
    input  logic [31:0] ex_pc,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_byte_en,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_dest,
    output logic [31:0] wb_data,
    output logic [31:0] wb_pc,
    output logic        misalign,
    output logic        bus_err
);

    // Counter only needs to reach TIMEOUT_CYCLES-1: the final no-ack cycle triggers the error
    localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Instruction fields
    logic [5:0] ex_opc;
    logic [4:0] ex_rt;
    logic [4:0] ex_rd;
    logic [5:0] ex_func;
    logic       unused_insn_bits;

    assign ex_opc           = ex_insn[31:26];
    assign ex_rt            = ex_insn[20:16];
    assign ex_rd            = ex_insn[15:11];
    assign ex_func          = ex_insn[5:0];
    assign unused_insn_bits = ^{ex_insn[25:21], ex_insn[10:6]};

    mem_op_e    ex_op;
    logic [4:0] ex_dest;
    logic       ex_wen;
    logic       ex_misaligned;

    assign ex_op = decode_mem_op(ex_opc);

    // Destination register and write enable; register 0 is never written
    always_comb begin
        ex_dest = 5'd0;
        ex_wen  = 1'b0;
        if (is_load(ex_op) || (ex_opc[5:3] == 3'b001)) begin
            ex_dest = ex_rt;
            ex_wen  = 1'b1;
        end else if (ex_opc == OPC_SPECIAL) begin
            ex_dest = ex_rd;
            ex_wen  = (ex_func != FUNC_JR);
        end else if (ex_opc == OPC_JAL) begin
            ex_dest = REG_LINK;
            ex_wen  = 1'b1;
        end
        if (ex_dest == 5'd0) begin
            ex_wen = 1'b0;
        end
    end

    // Byte ops are always aligned; half-words need an even address, words a multiple of four
    always_comb begin
        ex_misaligned = 1'b0;
        case (ex_op)
            MOP_LW, MOP_SW: ex_misaligned = (ex_result[1:0] != 2'b00);
            MOP_SH:         ex_misaligned = ex_result[0];
            default:        ex_misaligned = 1'b0;
        endcase
    end

    // State and held request
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    mem_op_e          op_q;
    logic [1:0]       addr_lo_q;
    logic [4:0]       dest_q;
    logic             wen_q;
    logic [31:0]      pc_q;
    logic             req_we_q;
    logic [31:0]      req_addr_q;
    logic [3:0]       req_be_q;
    logic [31:0]      req_wdata_q;

    // Registered writeback outputs
    logic             wb_valid_q;
    logic             wb_we_q;
    logic [4:0]       wb_dest_q;
    logic [31:0]      wb_data_q;
    logic [31:0]      wb_pc_q;
    logic             misalign_q;
    logic             bus_err_q;

    // One lane aligner serves both directions: store steering in IDLE, load extraction in WAIT
    mem_op_e     lane_op;
    logic [1:0]  lane_lo;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;

    assign lane_op = (state_q == S_WAIT) ? op_q      : ex_op;
    assign lane_lo = (state_q == S_WAIT) ? addr_lo_q : ex_result[1:0];

    mem_lane_align u_lane_align (
        .op         (lane_op),
        .addr_lo    (lane_lo),
        .store_data (ex_store_data),
        .rdata      (dmem_rdata),
        .byte_en    (lane_be),
        .wdata      (lane_wdata),
        .load_data  (lane_load)
    );

    // Stage FSM: accept in IDLE, hold the request in WAIT until ack or timeout
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= MOP_NONE;
            addr_lo_q   <= 2'b00;
            dest_q      <= 5'd0;
            wen_q       <= 1'b0;
            pc_q        <= 32'h0;
            req_we_q    <= 1'b0;
            req_addr_q  <= 32'h0;
            req_be_q    <= 4'b0000;
            req_wdata_q <= 32'h0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_dest_q   <= 5'd0;
            wb_data_q   <= 32'h0;
            wb_pc_q     <= 32'h0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ex_valid) begin
                        if (ex_op == MOP_NONE) begin
                            wb_valid_q <= 1'b1;
                            wb_we_q    <= ex_wen;
                            wb_dest_q  <= ex_dest;
                            wb_data_q  <= ex_result;
                            wb_pc_q    <= ex_pc;
                        end else if (ex_misaligned) begin
                            // Squash: retire without a register write and flag it
                            wb_valid_q <= 1'b1;
                            wb_dest_q  <= ex_dest;
                            wb_data_q  <= ex_result;
                            wb_pc_q    <= ex_pc;
                            misalign_q <= 1'b1;
                        end else begin
                            state_q     <= S_WAIT;
                            cnt_q       <= '0;
                            op_q        <= ex_op;
                            addr_lo_q   <= ex_result[1:0];
                            dest_q      <= ex_dest;
                            wen_q       <= ex_wen;
                            pc_q        <= ex_pc;
                            req_we_q    <= is_store(ex_op);
                            req_addr_q  <= {ex_result[31:2], 2'b00};
                            req_be_q    <= lane_be;
                            req_wdata_q <= lane_wdata;
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        // Ack wins over a timeout landing in the same cycle
                        state_q    <= S_IDLE;
                        wb_valid_q <= 1'b1;
                        wb_we_q    <= is_load(op_q) && wen_q;
                        wb_dest_q  <= dest_q;
                        wb_data_q  <= is_load(op_q) ? lane_load : 32'h0;
                        wb_pc_q    <= pc_q;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q    <= S_IDLE;
                        wb_valid_q <= 1'b1;
                        wb_dest_q  <= dest_q;
                        wb_data_q  <= 32'h0;
                        wb_pc_q    <= pc_q;
                        bus_err_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Request and stall come straight from the state register so reset drops them at once
    assign mem_stall    = (state_q == S_WAIT);
    assign dmem_req     = (state_q == S_WAIT);
    assign dmem_we      = req_we_q;
    assign dmem_addr    = req_addr_q;
    assign dmem_byte_en = req_be_q;
    assign dmem_wdata   = req_wdata_q;

    assign wb_valid     = wb_valid_q;
    assign wb_we        = wb_we_q;
    assign wb_dest      = wb_dest_q;
    assign wb_data      = wb_data_q;
    assign wb_pc        = wb_pc_q;
    assign misalign     = misalign_q;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads, stores, pass-through, misalign, timeout, async reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// A second instance with a short timeout exercises the bus-error path.
module tb_mem_access_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ex_valid, ex_valid_to;
    logic [31:0] ex_insn, ex_result, ex_store_data, ex_pc;
    logic        dmem_ack, dmem_ack_to;
    logic [31:0] dmem_rdata;

    logic        mem_stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_byte_en;
    logic        wb_valid, wb_we, misalign, bus_err;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data, wb_pc;

    logic        mem_stall_t, dmem_req_t, dmem_we_t;
    logic [31:0] dmem_addr_t, dmem_wdata_t;
    logic [3:0]  dmem_byte_en_t;
    logic        wb_valid_t, wb_we_t, misalign_t, bus_err_t;
    logic [4:0]  wb_dest_t;
    logic [31:0] wb_data_t, wb_pc_t;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    mem_access_stage #(.TIMEOUT_CYCLES(64)) dut (
        .clock(clock), .reset_n(reset_n),
        .ex_valid(ex_valid), .ex_insn(ex_insn), .ex_result(ex_result),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc),
        .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_byte_en(dmem_byte_en), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
        .wb_pc(wb_pc), .misalign(misalign), .bus_err(bus_err)
    );

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut_to (
        .clock(clock), .reset_n(reset_n),
        .ex_valid(ex_valid_to), .ex_insn(ex_insn), .ex_result(ex_result),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc),
        .mem_stall(mem_stall_t), .dmem_req(dmem_req_t), .dmem_we(dmem_we_t),
        .dmem_addr(dmem_addr_t), .dmem_byte_en(dmem_byte_en_t), .dmem_wdata(dmem_wdata_t),
        .dmem_ack(dmem_ack_to), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid_t), .wb_we(wb_we_t), .wb_dest(wb_dest_t), .wb_data(wb_data_t),
        .wb_pc(wb_pc_t), .misalign(misalign_t), .bus_err(bus_err_t)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n       = 1'b0;
        ex_valid      = 1'b0;
        ex_valid_to   = 1'b0;
        ex_insn       = 32'h0;
        ex_result     = 32'h0;
        ex_store_data = 32'h0;
        ex_pc         = 32'h0;
        dmem_ack      = 1'b0;
        dmem_ack_to   = 1'b0;
        dmem_rdata    = 32'h0;

        // Reset state
        #2;
        chk("rst_req",      dmem_req, 0);
        chk("rst_stall",    mem_stall, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_addr",     dmem_addr, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_bus_err",  bus_err, 0);
        step();
        step();
        reset_n = 1'b1;

        // LB r8, 0x1002 ; next instruction LBU r9 held behind it
        ex_valid = 1'b1; ex_insn = 32'h8008_0000; ex_result = 32'h0000_1002; ex_pc = 32'h100;
        step();
        chk("lb_req",   dmem_req, 1);
        chk("lb_stall", mem_stall, 1);
        chk("lb_addr",  dmem_addr, 32'h0000_1000);
        chk("lb_we",    dmem_we, 0);
        chk("lb_wbv0",  wb_valid, 0);
        ex_insn = 32'h9009_0000; ex_result = 32'h0000_1002; ex_pc = 32'h104;
        dmem_ack = 1'b1; dmem_rdata = 32'h1122_8344;
        step();
        chk("lb_wbv",   wb_valid, 1);
        chk("lb_data",  wb_data, 32'hFFFF_FF83);
        chk("lb_wbwe",  wb_we, 1);
        chk("lb_dest",  wb_dest, 5'd8);
        chk("lb_pc",    wb_pc, 32'h100);
        chk("lb_done",  dmem_req, 0);
        dmem_ack = 1'b0;
        step();
        chk("lbu_req",  dmem_req, 1);
        chk("lbu_wbv0", wb_valid, 0);
        ex_valid = 1'b0;
        dmem_ack = 1'b1;
        step();
        chk("lbu_wbv",  wb_valid, 1);
        chk("lbu_data", wb_data, 32'h0000_0083);
        chk("lbu_dest", wb_dest, 5'd9);
        chk("lbu_pc",   wb_pc, 32'h104);
        dmem_ack = 1'b0;

        // SB r3, 0x2003 with ack on the fifth WAIT cycle
        ex_valid = 1'b1; ex_insn = 32'hA003_0000; ex_result = 32'h0000_2003;
        ex_store_data = 32'hAABB_CCDD; ex_pc = 32'h200;
        step();
        ex_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("sb_be",    dmem_byte_en, 4'b0001);
            chk("sb_wdata", dmem_wdata, 32'hDDDD_DDDD);
            chk("sb_addr",  dmem_addr, 32'h0000_2000);
            chk("sb_stall", mem_stall, 1);
            chk("sb_we",    dmem_we, 1);
            chk("sb_wbv0",  wb_valid, 0);
            if (i == 4) dmem_ack = 1'b1;
            step();
        end
        chk("sb_wbv",   wb_valid, 1);
        chk("sb_wbwe",  wb_we, 0);
        chk("sb_req0",  dmem_req, 0);
        chk("sb_stal0", mem_stall, 0);
        dmem_ack = 1'b0;

        // LW r4, 0x6 is misaligned: squashed without a request
        ex_valid = 1'b1; ex_insn = 32'h8C04_0000; ex_result = 32'h0000_0006; ex_pc = 32'h300;
        step();
        chk("mis_pulse", misalign, 1);
        chk("mis_wbv",   wb_valid, 1);
        chk("mis_wbwe",  wb_we, 0);
        chk("mis_req",   dmem_req, 0);
        chk("mis_pc",    wb_pc, 32'h300);

        // ADD rd=5 then ADD rd=0, back to back
        ex_insn = 32'h0000_2820; ex_result = 32'h1234_5678; ex_pc = 32'h400;
        step();
        chk("add5_wbv",  wb_valid, 1);
        chk("add5_wbwe", wb_we, 1);
        chk("add5_dest", wb_dest, 5'd5);
        chk("add5_data", wb_data, 32'h1234_5678);
        chk("add5_pc",   wb_pc, 32'h400);
        chk("mis_end",   misalign, 0);
        ex_insn = 32'h0000_0020; ex_result = 32'h0000_0009; ex_pc = 32'h404;
        step();
        chk("add0_wbv",  wb_valid, 1);
        chk("add0_wbwe", wb_we, 0);
        ex_valid = 1'b0;
        step();
        chk("bubble",    wb_valid, 0);

        // JR never writes; JAL writes r31
        ex_valid = 1'b1; ex_insn = 32'h03E0_F808; ex_result = 32'h0000_0077; ex_pc = 32'h410;
        step();
        chk("jr_wbv",    wb_valid, 1);
        chk("jr_wbwe",   wb_we, 0);
        ex_insn = 32'h0C00_0000; ex_result = 32'h0000_0418; ex_pc = 32'h414;
        step();
        chk("jal_wbwe",  wb_we, 1);
        chk("jal_dest",  wb_dest, 5'd31);
        chk("jal_data",  wb_data, 32'h0000_0418);
        ex_valid = 1'b0;

        // SW with no ack on the short-timeout instance
        ex_valid_to = 1'b1; ex_insn = 32'hAC02_0000; ex_result = 32'h0000_3000;
        ex_store_data = 32'h1122_3344; ex_pc = 32'h500;
        step();
        ex_valid_to = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_req",   dmem_req_t, 1);
            chk("to_be",    dmem_byte_en_t, 4'b1111);
            chk("to_noerr", bus_err_t, 0);
            step();
        end
        chk("to_buserr", bus_err_t, 1);
        chk("to_wbv",    wb_valid_t, 1);
        chk("to_wbwe",   wb_we_t, 0);
        chk("to_req0",   dmem_req_t, 0);
        chk("to_pc",     wb_pc_t, 32'h500);
        dmem_ack_to = 1'b1;
        step();
        chk("late_err",  bus_err_t, 0);
        chk("late_wbv",  wb_valid_t, 0);
        chk("late_req",  dmem_req_t, 0);
        dmem_ack_to = 1'b0;

        // Ack on the last permitted cycle completes normally
        ex_valid_to = 1'b1; ex_pc = 32'h504;
        step();
        ex_valid_to = 1'b0;
        step();
        step();
        step();
        dmem_ack_to = 1'b1;
        step();
        chk("edge_err",  bus_err_t, 0);
        chk("edge_wbv",  wb_valid_t, 1);
        chk("edge_req",  dmem_req_t, 0);
        dmem_ack_to = 1'b0;

        // Async reset in the middle of a WAIT
        ex_valid = 1'b1; ex_insn = 32'h8C04_0000; ex_result = 32'h0000_0040; ex_pc = 32'h600;
        step();
        ex_valid = 1'b0;
        chk("rw_req1",   dmem_req, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rw_req0",   dmem_req, 0);
        chk("rw_stall0", mem_stall, 0);
        chk("rw_wbv0",   wb_valid, 0);
        step();
        chk("rw_hold",   wb_valid, 0);
        reset_n = 1'b1;
        ex_valid = 1'b1; ex_insn = 32'h8C06_0000; ex_result = 32'h0000_0080; ex_pc = 32'h700;
        step();
        ex_valid = 1'b0;
        chk("rl_req",    dmem_req, 1);
        chk("rl_addr",   dmem_addr, 32'h0000_0080);
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        step();
        dmem_ack = 1'b0;
        chk("rl_wbv",    wb_valid, 1);
        chk("rl_data",   wb_data, 32'hCAFE_F00D);
        chk("rl_dest",   wb_dest, 5'd6);
        chk("rl_wbwe",   wb_we, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
